n64_vinfo_meas: RTL and testbench

Parametrised video-info extractor sitting between the sync/data de-mux input stage and the line-doubler/scanline logic. Tracks the data counter and classifies 240p/288p vs. 480i/576i and PAL vs. NTSC. Classification uses a full per-field line count and per-field parity instead of a 2-bit heuristic. Exports the measured lines-per-field, a validity flag and a mode-change strobe.

---
 rtl/n64_vinfo_meas_pkg.sv | 48 ++++
 rtl/n64_vinfo_meas_if.sv | 18 +
 rtl/n64_vinfo_hyst.sv | 66 ++++++
 rtl/n64_vinfo_meas.sv | 141 ++++++++++++++
 tb/tb_n64_vinfo_meas.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/n64_vinfo_meas_pkg.sv
// -----------------------------------------------------------------------------
// n64_vinfo_meas_pkg
// Shared constants and helpers for the N64 video-info extractor:
//   - sync bit positions inside the 4-bit sync sample
//   - default parameter values for n64_vinfo_meas / n64_vinfo_hyst
//   - bit offsets of the fields packed into vinfo_o
//   - edge-decoding helper for one sync sample pair
// Optional feature macro used by this slice: VINFO_HYST_EN (see n64_vinfo_hyst).
// -----------------------------------------------------------------------------
package n64_vinfo_meas_pkg;

  // Positions inside Sync_pre / Sync_cur.
  localparam int VSYNC_IDX = 3;
  localparam int HSYNC_IDX = 1;

  // Default parameter values.
  localparam int DEF_DATA_CNT_W  = 2;
  localparam int DEF_LINE_CNT_W  = 10;
  localparam int DEF_PAL_THRESH  = 288;
  localparam int DEF_HYST_FIELDS = 2;

  // vinfo_o = {data_cnt, n64_480i, vmode}
  localparam int VINFO_VMODE_OFS = 0;
  localparam int VINFO_480I_OFS  = 1;
  localparam int VINFO_DCNT_OFS  = 2;

  typedef struct packed {
    logic v_rise;
    logic v_fall;
    logic h_rise;
    logic h_fall;
  } sync_edges_t;

  // Edges only exist in sync sample cycles (dsync_n low); otherwise all zero.
  function automatic sync_edges_t decode_edges(input logic dsync_n,
                                               input logic v_pre,
                                               input logic v_cur,
                                               input logic h_pre,
                                               input logic h_cur);
    sync_edges_t e;
    e.v_rise = !dsync_n && !v_pre &&  v_cur;
    e.v_fall = !dsync_n &&  v_pre && !v_cur;
    e.h_rise = !dsync_n && !h_pre &&  h_cur;
    e.h_fall = !dsync_n &&  h_pre && !h_cur;
    return e;
  endfunction

endpackage

// File: rtl/n64_vinfo_meas_if.sv
// -----------------------------------------------------------------------------
// n64_vinfo_meas_if
// Sync sample bus from the sync/data de-mux stage into n64_vinfo_meas.
//   nDSYNC   : low = sync sample cycle
//   Sync_pre : previous sync sample, [3]=nVSYNC, [1]=nHSYNC
//   Sync_cur : current sync sample, same bit order
// Modports: master (de-mux stage, drives), slave (video-info extractor).
// -----------------------------------------------------------------------------
interface n64_vinfo_meas_if;

  logic       nDSYNC;
  logic [3:0] Sync_pre;
  logic [3:0] Sync_cur;

  modport master (output nDSYNC, output Sync_pre, output Sync_cur);
  modport slave  (input  nDSYNC, input  Sync_pre, input  Sync_cur);

endinterface

// File: rtl/n64_vinfo_hyst.sv
// -----------------------------------------------------------------------------
// n64_vinfo_hyst
// One-bit candidate filter for a committed video-mode bit.
//   nCLK      : pixel clock, logic acts on its falling edge
//   nRST      : asynchronous active-low reset
//   update    : a trustworthy field ended; cand is valid this cycle
//   cand      : candidate value for the committed bit
//   committed : filtered (committed) bit, resets to RST_VAL
//   changed   : one-cycle strobe in the cycle committed toggles
// Macro VINFO_HYST_EN: when defined, cand must differ from committed on
// HYST_FIELDS consecutive updates before committed follows it; an agreeing
// update clears the run. When undefined, committed follows cand on every
// update and HYST_FIELDS has no effect.
// -----------------------------------------------------------------------------
module n64_vinfo_hyst
  import n64_vinfo_meas_pkg::*;
#(
  parameter int HYST_FIELDS = DEF_HYST_FIELDS,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic nCLK,
  input  logic nRST,
  input  logic update,
  input  logic cand,
  output logic committed,
  output logic changed
);

  localparam int HYST_MIN = (HYST_FIELDS < 1) ? 1 : HYST_FIELDS;
  localparam int AGREE_W  = $clog2(HYST_MIN + 1);

`ifdef VINFO_HYST_EN
  localparam int N_AGREE = HYST_MIN;
`else
  // A single disagreeing field commits immediately (legacy behaviour).
  localparam int N_AGREE = 1;
`endif

  // Counts consecutive updates whose candidate differs from committed.
  // Being a one-bit value, "differs" also means "agrees on the same value".
  logic [AGREE_W-1:0] agree_cnt;

  // NOTE: every flop, including the agreement counter, has an async reset so a
  // mid-field reset leaves no stale hysteresis history behind.
  always_ff @(negedge nCLK or negedge nRST) begin
    if (!nRST) begin
      committed <= RST_VAL;
      changed   <= 1'b0;
      agree_cnt <= '0;
    end else begin
      changed <= 1'b0;
      if (update) begin
        if (cand == committed) begin
          agree_cnt <= '0;
        end else if (int'(agree_cnt) + 1 >= N_AGREE) begin
          committed <= cand;
          changed   <= 1'b1;
          agree_cnt <= '0;
        end else begin
          agree_cnt <= agree_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/n64_vinfo_meas.sv
// -----------------------------------------------------------------------------
// n64_vinfo_meas
// Video-info extractor between the sync/data de-mux and the line-doubler.
// Counts nHSYNC rising edges per field, tracks field parity and classifies
// 240p/288p vs 480i/576i and NTSC vs PAL. All logic on the falling nCLK edge.
// Ports:
//   nCLK              : pixel clock (falling edge active)
//   nRST              : asynchronous active-low reset
//   sync_bus          : n64_vinfo_meas_if.slave (nDSYNC, Sync_pre, Sync_cur)
//   vinfo_o           : {data_cnt, n64_480i, vmode}
//   lines_per_field_o : nHSYNC rising edges in the last complete field
//   vinfo_valid_o     : classification trustworthy
//   mode_change_o     : one-cycle strobe when n64_480i or vmode is committed
//                       to a new value
// Macro VINFO_HYST_EN: enables field hysteresis in n64_vinfo_hyst.
// -----------------------------------------------------------------------------
module n64_vinfo_meas
  import n64_vinfo_meas_pkg::*;
#(
  parameter int DATA_CNT_W  = DEF_DATA_CNT_W,
  parameter int LINE_CNT_W  = DEF_LINE_CNT_W,
  parameter int PAL_THRESH  = DEF_PAL_THRESH,
  parameter int HYST_FIELDS = DEF_HYST_FIELDS
) (
  input  logic                  nCLK,
  input  logic                  nRST,
  n64_vinfo_meas_if.slave       sync_bus,
  output logic [DATA_CNT_W+1:0] vinfo_o,
  output logic [LINE_CNT_W-1:0] lines_per_field_o,
  output logic                  vinfo_valid_o,
  output logic                  mode_change_o
);

  localparam logic [LINE_CNT_W-1:0] LINE_MAX = '1;

  sync_edges_t           edg;
  logic [DATA_CNT_W-1:0] data_cnt;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic [1:0]            fields_seen;
  logic [1:0]            fields_next;
  logic                  parity;
  logic                  cand_480i;
  logic                  field_sat;
  logic                  cand_pal;
  logic                  field_ok;
  logic                  n64_480i;
  logic                  vmode;
  logic                  chg_480i;
  logic                  chg_vmode;

  // CSYNC/CLAMP bits of the sample are not needed for classification.
  logic unused_sync_bits;
  assign unused_sync_bits = ^{sync_bus.Sync_pre[2], sync_bus.Sync_pre[0],
                              sync_bus.Sync_cur[2], sync_bus.Sync_cur[0]};

  assign edg = decode_edges(sync_bus.nDSYNC,
                            sync_bus.Sync_pre[VSYNC_IDX], sync_bus.Sync_cur[VSYNC_IDX],
                            sync_bus.Sync_pre[HSYNC_IDX], sync_bus.Sync_cur[HSYNC_IDX]);

  // NOTE: always_comb gives every output a default first, so no latch appears.
  always_comb begin
    field_sat   = 1'b0;
    fields_next = fields_seen;
    cand_pal    = 1'b0;
    field_ok    = 1'b0;
    field_sat   = (line_cnt == LINE_MAX);
    fields_next = (fields_seen == 2'd2) ? 2'd2 : fields_seen + 2'd1;
    cand_pal    = (32'(line_cnt) > PAL_THRESH);
    // Only complete, non-saturated fields may move the committed bits.
    field_ok    = edg.v_rise && (fields_next == 2'd2) && !field_sat;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(negedge nCLK or negedge nRST) begin
    if (!nRST) begin
      data_cnt          <= '0;
      line_cnt          <= '0;
      lines_per_field_o <= '0;
      fields_seen       <= 2'd0;
      vinfo_valid_o     <= 1'b0;
      parity            <= 1'b0;
      // Matches the committed n64_480i reset value, so nothing moves before
      // a real falling nVSYNC has been seen.
      cand_480i         <= 1'b1;
    end else begin
      data_cnt <= sync_bus.nDSYNC ? data_cnt + 1'b1 : DATA_CNT_W'(1);

      // nVSYNC takes priority: a coincident hsync edge belongs to no field.
      if (edg.v_rise) begin
        lines_per_field_o <= line_cnt;
        line_cnt          <= '0;
        fields_seen       <= fields_next;
        vinfo_valid_o     <= (fields_next == 2'd2) && !field_sat;
      end else if (edg.h_rise && !field_sat) begin
        line_cnt <= line_cnt + 1'b1;
      end

      // Odd field: nHSYNC falls together with nVSYNC.
      if (edg.v_fall) begin
        parity    <= edg.h_fall;
        cand_480i <= (edg.h_fall != parity);
      end
    end
  end

  n64_vinfo_hyst #(
    .HYST_FIELDS (HYST_FIELDS),
    .RST_VAL     (1'b1)
  ) u_hyst_480i (
    .nCLK      (nCLK),
    .nRST      (nRST),
    .update    (field_ok),
    .cand      (cand_480i),
    .committed (n64_480i),
    .changed   (chg_480i)
  );

  n64_vinfo_hyst #(
    .HYST_FIELDS (HYST_FIELDS),
    .RST_VAL     (1'b0)
  ) u_hyst_vmode (
    .nCLK      (nCLK),
    .nRST      (nRST),
    .update    (field_ok),
    .cand      (cand_pal),
    .committed (vmode),
    .changed   (chg_vmode)
  );

  always_comb begin
    vinfo_o                                  = '0;
    vinfo_o[VINFO_DCNT_OFS +: DATA_CNT_W]    = data_cnt;
    vinfo_o[VINFO_480I_OFS]                  = n64_480i;
    vinfo_o[VINFO_VMODE_OFS]                 = vmode;
  end

  // Both strobes are registered and only fire on trustworthy fields.
  assign mode_change_o = chg_480i | chg_vmode;

endmodule

// File: tb/tb_n64_vinfo_meas.sv
// -----------------------------------------------------------------------------
// tb_n64_vinfo_meas
// Directed bench for n64_vinfo_meas with default parameters
// (DATA_CNT_W=2, LINE_CNT_W=10, PAL_THRESH=288, HYST_FIELDS=2).
// Expected values follow the build: with VINFO_HYST_EN defined, committed
// bits move one trustworthy field later than in the default build.
// -----------------------------------------------------------------------------
module tb_n64_vinfo_meas;

`ifdef VINFO_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  localparam logic [3:0] IDLE = 4'b1111;

  logic       nCLK = 1'b1;
  logic       nRST = 1'b0;
  logic [3:0] vinfo;
  logic [9:0] lpf;
  logic       valid;
  logic       mc;

  int checks    = 0;
  int failures  = 0;
  int mc_pulses = 0;

  n64_vinfo_meas_if bus ();

  n64_vinfo_meas dut (
    .nCLK              (nCLK),
    .nRST              (nRST),
    .sync_bus          (bus),
    .vinfo_o           (vinfo),
    .lines_per_field_o (lpf),
    .vinfo_valid_o     (valid),
    .mode_change_o     (mc)
  );

  always #5 nCLK = ~nCLK;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One nCLK cycle: drive after the rising edge, DUT acts on the falling edge,
  // outputs are sampled 1 time unit later.
  task automatic cyc(input logic ds, input logic [3:0] pre, input logic [3:0] cur);
    @(posedge nCLK);
    bus.nDSYNC   = ds;
    bus.Sync_pre = pre;
    bus.Sync_cur = cur;
    @(negedge nCLK);
    #1;
    if (mc) mc_pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, IDLE, IDLE);
  endtask

  task automatic hs_lines(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'b1101, IDLE);
  endtask

  task automatic vs_fall(input bit odd);
    cyc(1'b0, IDLE, odd ? 4'b0101 : 4'b0111);
  endtask

  task automatic vs_rise(input bit with_hs);
    cyc(1'b0, with_hs ? 4'b0101 : 4'b0111, IDLE);
  endtask

  task automatic field(input int lines, input bit odd);
    vs_fall(odd);
    hs_lines(lines);
    vs_rise(1'b0);
  endtask

  initial begin
    bus.nDSYNC   = 1'b1;
    bus.Sync_pre = IDLE;
    bus.Sync_cur = IDLE;

    // Reset state
    #12;
    check("rst_vinfo", int'(vinfo), 'b0010);
    check("rst_lpf", int'(lpf), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_strobe", int'(mc), 0);
    @(negedge nCLK);
    #1 nRST = 1'b1;

    // Data counter only: 10 increments modulo 4
    idle(10);
    check("dcnt_vinfo", int'(vinfo), 'b1010);
    check("dcnt_valid", int'(valid), 0);
    check("dcnt_lpf", int'(lpf), 0);

    // NTSC progressive
    mc_pulses = 0;
    field(263, 1'b0);
    check("ntsc_f1_lpf", int'(lpf), 263);
    check("ntsc_f1_valid", int'(valid), 0);
    field(263, 1'b0);
    check("ntsc_f2_lpf", int'(lpf), 263);
    check("ntsc_f2_valid", int'(valid), 1);
    check("ntsc_f2_vinfo", int'(vinfo), HYST ? 'b0110 : 'b0100);
    check("ntsc_f2_strobe", int'(mc), HYST ? 0 : 1);
    field(263, 1'b0);
    check("ntsc_f3_vinfo", int'(vinfo), 'b0100);
    check("ntsc_pulses", mc_pulses, 1);

    // PAL interlaced, alternating parity
    mc_pulses = 0;
    field(313, 1'b1);
    check("pal_a_lpf", int'(lpf), 313);
    field(312, 1'b0);
    check("pal_b_lpf", int'(lpf), 312);
    check("pal_b_vinfo", int'(vinfo), 'b0111);
    field(313, 1'b1);
    check("pal_c_lpf", int'(lpf), 313);
    field(312, 1'b0);
    check("pal_d_lpf", int'(lpf), 312);
    check("pal_d_vinfo", int'(vinfo), 'b0111);
    check("pal_pulses", mc_pulses, 1);

    // Back to steady NTSC 240p, then a single PAL-length field
    mc_pulses = 0;
    repeat (3) field(263, 1'b0);
    check("n240_vinfo", int'(vinfo), 'b0100);
    check("n240_pulses", mc_pulses, 1);
    field(313, 1'b0);
    check("glitch_vinfo", int'(vinfo), HYST ? 'b0100 : 'b0101);
    check("glitch_strobe", int'(mc), HYST ? 0 : 1);
    field(263, 1'b0);
    check("glitch_back_vinfo", int'(vinfo), 'b0100);

    // Two consecutive PAL fields
    mc_pulses = 0;
    field(313, 1'b0);
    check("pal2_a_vinfo", int'(vinfo), HYST ? 'b0100 : 'b0101);
    field(313, 1'b0);
    check("pal2_b_vinfo", int'(vinfo), 'b0101);
    check("pal2_b_strobe", int'(mc), HYST ? 1 : 0);
    check("pal2_pulses", mc_pulses, 1);

    // Rising nVSYNC together with rising nHSYNC at line 262
    vs_fall(1'b0);
    hs_lines(262);
    vs_rise(1'b1);
    check("coinc_lpf", int'(lpf), 262);
    field(263, 1'b0);
    check("restart_lpf", int'(lpf), 263);
    check("restart_vinfo", int'(vinfo), 'b0100);

    // Line counter saturation
    vs_fall(1'b0);
    hs_lines(1100);
    vs_rise(1'b0);
    check("sat_lpf", int'(lpf), 1023);
    check("sat_valid", int'(valid), 0);
    check("sat_vinfo", int'(vinfo), 'b0100);
    check("sat_strobe", int'(mc), 0);
    field(263, 1'b0);
    check("recover_valid", int'(valid), 1);

    // Reset pulsed mid-field
    hs_lines(50);
    idle(3);
    @(posedge nCLK);
    #2 nRST = 1'b0;
    #1;
    check("midrst_vinfo", int'(vinfo), 'b0010);
    check("midrst_lpf", int'(lpf), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_strobe", int'(mc), 0);
    @(negedge nCLK);
    #1 nRST = 1'b1;

    // First field after release is partial and discarded
    hs_lines(40);
    field(263, 1'b0);
    check("partial_lpf", int'(lpf), 303);
    check("partial_valid", int'(valid), 0);
    field(263, 1'b0);
    check("post_lpf", int'(lpf), 263);
    check("post_valid", int'(valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
